// File: rtl/trig_interval_meter.sv
// rtl/trig_interval_meter.sv - trigger interval meter with saturating counter and valid/ready result
module trig_interval_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             trig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_ovf,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             missed,
  input  logic             missed_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_period;
  logic                   r_ovf;
  logic                   r_valid;
  logic                   r_missed;

  logic w_last;
  logic w_rise;
  logic w_capture;
  logic w_accept;
  logic w_drop;

  assign w_last    = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_last & ~r_dly;
  // A capture slot exists only while measuring; it either loads or is dropped.
  assign w_capture = (r_state == MEAS) & en & w_rise;
  assign w_accept  = w_capture & (~r_valid | period_ready);
  assign w_drop    = w_capture & r_valid & ~period_ready;

  assign period       = r_period;
  assign period_ovf   = r_ovf;
  assign period_valid = r_valid;
  assign missed       = r_missed;

  // Synchronize trig_in and keep one delayed copy for edge detection; runs in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], trig_in};
      r_dly  <= w_last;
    end
  end

  // Measurement FSM, interval counter and registered result/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= CNT_ZERO;
      r_period <= CNT_ZERO;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
      r_missed <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= CNT_ZERO;
          if (en) r_state <= ARM;
        end
        ARM: begin
          if (!en) begin
            r_state <= IDLE;
            r_cnt   <= CNT_ZERO;
          end else if (w_rise) begin
            // First edge after arming only opens the interval.
            r_state <= MEAS;
            r_cnt   <= CNT_ONE;
          end
        end
        MEAS: begin
          if (!en) begin
            r_state <= IDLE;
            r_cnt   <= CNT_ZERO;
          end else if (w_rise) begin
            r_cnt <= CNT_ONE;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= CNT_ZERO;
        end
      endcase

      // Disabling withdraws the result but leaves period/ovf readable.
      if (!en) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_period <= r_cnt;
        r_ovf    <= (r_cnt == CNT_MAX);
        r_valid  <= 1'b1;
      end else if (r_valid && period_ready) begin
        r_valid <= 1'b0;
      end

      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop) begin
        r_missed <= 1'b1;
      end else if (missed_clr) begin
        r_missed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trig_interval_meter.sv
// tb/tb_trig_interval_meter.sv - directed table-driven bench for trig_interval_meter
module tb_trig_interval_meter;

  localparam int CNT_W = 8;
  localparam int SYNC = 2;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             trig_in;
  logic [CNT_W-1:0] period;
  logic             period_ovf;
  logic             period_valid;
  logic             period_ready;
  logic             missed;
  logic             missed_clr;

  int n_checks = 0;
  int n_errors = 0;
  int elapsed  = 0;

  trig_interval_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .trig_in      (trig_in),
    .period       (period),
    .period_ovf   (period_ovf),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .missed       (missed),
    .missed_clr   (missed_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   gap;
    logic rdy;
    logic exp_valid;
    int   exp_period;
    logic exp_ovf;
    logic exp_missed;
    logic exp_valid_next;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Rising edge 'gap' negedges after the previous one; returns at the first
  // negedge after the capture posedge (SYNC+1 posedges after trig_in rose).
  task automatic edge_to_sample(input int gap, input logic late_ready);
    repeat (gap - elapsed) @(negedge clk);
    trig_in = 1'b1;
    repeat (SYNC) @(negedge clk);
    if (late_ready) period_ready = 1'b1;
    @(negedge clk);
    if (late_ready) period_ready = 1'b0;
    trig_in = 1'b0;
    elapsed = SYNC + 1;
  endtask

  task automatic step();
    @(negedge clk);
    elapsed++;
  endtask

  initial begin
    vecs[0] = '{10,  1'b1, 1'b0, 0,   1'b0, 1'b0, 1'b0};
    vecs[1] = '{100, 1'b1, 1'b1, 100, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{100, 1'b1, 1'b1, 100, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{300, 1'b1, 1'b1, 255, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{50,  1'b1, 1'b1, 50,  1'b0, 1'b0, 1'b0};
    vecs[5] = '{40,  1'b0, 1'b1, 40,  1'b0, 1'b0, 1'b1};
    vecs[6] = '{45,  1'b0, 1'b1, 40,  1'b0, 1'b1, 1'b1};
    vecs[7] = '{60,  1'b0, 1'b1, 40,  1'b0, 1'b1, 1'b1};

    rst_n = 1'b0; en = 1'b0; trig_in = 1'b0; period_ready = 1'b0; missed_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", int'(period_valid), 0);
    chk("reset_period", int'(period), 0);
    chk("reset_ovf", int'(period_ovf), 0);
    chk("reset_missed", int'(missed), 0);

    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b1;
    elapsed = 0;

    for (int i = 0; i < 8; i++) begin
      period_ready = vecs[i].rdy;
      edge_to_sample(vecs[i].gap, 1'b0);
      chk($sformatf("row%0d_valid", i), int'(period_valid), int'(vecs[i].exp_valid));
      chk($sformatf("row%0d_period", i), int'(period), vecs[i].exp_period);
      chk($sformatf("row%0d_ovf", i), int'(period_ovf), int'(vecs[i].exp_ovf));
      chk($sformatf("row%0d_missed", i), int'(missed), int'(vecs[i].exp_missed));
      step();
      chk($sformatf("row%0d_valid_next", i), int'(period_valid), int'(vecs[i].exp_valid_next));
    end

    // Handshake releases the held result, then clear the sticky flag.
    period_ready = 1'b1;
    step();
    chk("ack_valid", int'(period_valid), 0);
    period_ready = 1'b0;
    missed_clr = 1'b1;
    step();
    missed_clr = 1'b0;
    chk("clr_missed", int'(missed), 0);
    chk("clr_period_kept", int'(period), 40);

    // Capture while valid with ready high only on the capture cycle.
    edge_to_sample(50, 1'b0);
    chk("b_first_valid", int'(period_valid), 1);
    chk("b_first_period", int'(period), 50);
    edge_to_sample(30, 1'b1);
    chk("b_same_cycle_valid", int'(period_valid), 1);
    chk("b_same_cycle_period", int'(period), 30);
    chk("b_same_cycle_missed", int'(missed), 0);
    step();
    chk("b_held_valid", int'(period_valid), 1);

    // Disable mid-measurement, re-enable with trig_in already high.
    en = 1'b0;
    step();
    chk("dis_valid", int'(period_valid), 0);
    chk("dis_period_kept", int'(period), 30);
    trig_in = 1'b1;
    repeat (4) @(negedge clk);
    en = 1'b1;
    repeat (6) @(negedge clk);
    chk("reen_level_no_capture", int'(period_valid), 0);
    trig_in = 1'b0;
    repeat (3) @(negedge clk);
    elapsed = 0;
    edge_to_sample(5, 1'b0);
    chk("reen_first_edge_valid", int'(period_valid), 0);
    chk("reen_first_edge_period", int'(period), 30);
    edge_to_sample(60, 1'b0);
    chk("reen_second_valid", int'(period_valid), 1);
    chk("reen_second_period", int'(period), 60);
    chk("reen_second_ovf", int'(period_ovf), 0);
    edge_to_sample(40, 1'b0);
    chk("reen_drop_period", int'(period), 60);
    chk("reen_drop_missed", int'(missed), 1);

    // Asynchronous reset between clock edges, mid-interval.
    repeat (20) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("areset_valid", int'(period_valid), 0);
    chk("areset_period", int'(period), 0);
    chk("areset_ovf", int'(period_ovf), 0);
    chk("areset_missed", int'(missed), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    elapsed = 0;
    edge_to_sample(8, 1'b0);
    chk("post_reset_first_edge", int'(period_valid), 0);
    edge_to_sample(25, 1'b0);
    chk("post_reset_valid", int'(period_valid), 1);
    chk("post_reset_period", int'(period), 25);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
